// File: rtl/multicycle_alu.sv
// multicycle_alu: handshaked ALU. Single-cycle ops register their result at the
// accept edge. MULT/DIV iterate one bit per clock (shift-add / restoring) on
// operand magnitudes and apply the sign on the last iteration.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             div_zero
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t             state;
  state_t             next_state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;       // {remainder|partial product, quotient|multiplier}
  logic [WIDTH-1:0]   opnd;      // divisor / multiplicand magnitude
  logic [WIDTH-1:0]   a_hold;    // original a, returned as remainder on divide-by-zero
  logic               is_div;
  logic               q_neg;     // product / quotient needs negation
  logic               r_neg;     // remainder needs negation
  logic               b_zero;

  logic               accept;
  logic               op_multi;
  logic               op_signed;
  logic               op_div;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [SHW-1:0]     sh;
  logic [WIDTH-1:0]   sc_lo;
  logic               sc_ov;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fin_lo;
  logic [WIDTH-1:0]   fin_hi;

  assign accept    = in_valid & in_ready;
  assign op_multi  = (op >= 4'd11) && (op <= 4'd14);
  assign op_signed = (op == 4'd11) || (op == 4'd13);
  assign op_div    = (op == 4'd13) || (op == 4'd14);
  assign a_neg     = op_signed & a[MSB];
  assign b_neg     = op_signed & b[MSB];
  assign a_mag     = a_neg ? ({WIDTH{1'b0}} - a) : a;
  assign b_mag     = b_neg ? ({WIDTH{1'b0}} - b) : b;
  assign sum       = a + b;
  assign diff      = a - b;
  assign sh        = b[SHW-1:0];

  // Single-cycle result and signed-overflow flag
  always_comb begin
    sc_lo = {WIDTH{1'b0}};
    sc_ov = 1'b0;
    case (op)
      4'd0: begin
        sc_lo = sum;
        sc_ov = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      4'd1: begin
        sc_lo = diff;
        sc_ov = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      4'd2:    sc_lo = a & b;
      4'd3:    sc_lo = a | b;
      4'd4:    sc_lo = a ^ b;
      4'd5:    sc_lo = ~(a | b);
      4'd6:    sc_lo = a << sh;
      4'd7:    sc_lo = a >> sh;
      4'd8:    sc_lo = $signed(a) >>> sh;
      4'd9:    sc_lo = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd10:   sc_lo = {{(WIDTH-1){1'b0}}, (a < b)};
      default: sc_lo = {WIDTH{1'b0}};
    endcase
  end

  // One shift-add or restoring-divide step on the magnitudes
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[MSB]};
    rem_ge   = rem_sh >= {1'b0, opnd};
    rem_new  = rem_ge ? WIDTH'(rem_sh - {1'b0, opnd}) : rem_sh[WIDTH-1:0];
    if (is_div) begin
      acc_next = {rem_new, acc[WIDTH-2:0], rem_ge};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign fix-up and divide-by-zero override applied on the last iteration
  always_comb begin
    prod = q_neg ? ({(2*WIDTH){1'b0}} - acc_next) : acc_next;
    if (is_div) begin
      if (b_zero) begin
        fin_lo = {WIDTH{1'b1}};
        fin_hi = a_hold;
      end else begin
        fin_lo = q_neg ? ({WIDTH{1'b0}} - acc_next[WIDTH-1:0]) : acc_next[WIDTH-1:0];
        fin_hi = r_neg ? ({WIDTH{1'b0}} - acc_next[2*WIDTH-1:WIDTH]) : acc_next[2*WIDTH-1:WIDTH];
      end
    end else begin
      fin_lo = prod[WIDTH-1:0];
      fin_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = op_multi ? BUSY : DONE;
        else        next_state = IDLE;
      end
      BUSY: begin
        if (cnt == CNT_ONE) next_state = DONE;
        else                next_state = BUSY;
      end
      DONE: begin
        if (accept)         next_state = op_multi ? BUSY : DONE;
        else if (out_ready) next_state = IDLE;
        else                next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // FSM handshake outputs
  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid = (state == DONE);
  end

  // Datapath: operand capture, iteration and result/flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= {CW{1'b0}};
      acc       <= {(2*WIDTH){1'b0}};
      opnd      <= {WIDTH{1'b0}};
      a_hold    <= {WIDTH{1'b0}};
      is_div    <= 1'b0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      b_zero    <= 1'b0;
      result_lo <= {WIDTH{1'b0}};
      result_hi <= {WIDTH{1'b0}};
      zero      <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
      div_zero  <= 1'b0;
    end else if (accept) begin
      if (op_multi) begin
        cnt    <= CNT_INIT;
        acc    <= {{WIDTH{1'b0}}, a_mag};
        opnd   <= b_mag;
        a_hold <= a;
        is_div <= op_div;
        q_neg  <= a_neg ^ b_neg;
        r_neg  <= a_neg;
        b_zero <= (b == {WIDTH{1'b0}});
      end else begin
        result_lo <= sc_lo;
        result_hi <= {WIDTH{1'b0}};
        zero      <= (sc_lo == {WIDTH{1'b0}});
        negative  <= sc_lo[MSB];
        overflow  <= sc_ov;
        div_zero  <= 1'b0;
      end
    end else if (state == BUSY) begin
      acc <= acc_next;
      cnt <= cnt - CNT_ONE;
      if (cnt == CNT_ONE) begin
        result_lo <= fin_lo;
        result_hi <= fin_hi;
        zero      <= (fin_lo == {WIDTH{1'b0}});
        negative  <= fin_lo[MSB];
        overflow  <= 1'b0;
        div_zero  <= is_div & b_zero;
      end else begin
        result_lo <= result_lo;
      end
    end else begin
      cnt <= cnt;
    end
  end

endmodule
